logic_unit_pipe: RTL

- Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit combinational inverter in the ALU.
- Supports 8 bitwise ops over WIDTH bits, two register stages, valid/ready handshake on both sides.
- Sits in the ALU datapath between operand fetch and result writeback, and stalls cleanly under writeback backpressure.

---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_unit_pipe_bitop.sv | 29 ++
 rtl/logic_unit_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and default widths for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int OP_W          = 3;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } logic_op_e;

endpackage

// File: rtl/logic_unit_pipe_bitop.sv
// Combinational bitwise operator, fully decoded over the 3-bit opcode.
module logic_bitop
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic_op_e        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: result gets a value on every path (default first) so no latch is inferred.
    result = a;
    unique case (op)
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit. Define LOGIC_UNIT_FLAGS_EN to add
// registered zero/ones/parity flags on the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OP_W  = logic_unit_pkg::OP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
`endif
  output logic [1:0]       occupancy
);

  logic             s1_valid, s2_valid;
  logic_op_e        s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH-1:0] s2_result;
  logic [WIDTH-1:0] alu_result;
  logic             s1_adv, s2_adv, in_fire, s2_load;

  // A stage may advance when it is empty or the stage after it is moving.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign s2_load  = s2_adv && s1_valid;

  // NOTE: all state below uses non-blocking assignments so both stages sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // NOTE: data registers are cleared on reset and only load alongside a valid beat, to cut toggling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_op <= OP_NOT;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (in_fire) begin
      s1_op <= logic_op_e'(in_op);
      s1_a  <= in_a;
      s1_b  <= in_b;
    end
  end

  logic_bitop #(.WIDTH(WIDTH)) u_bitop (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_result <= '0;
    end else if (s2_load) begin
      s2_result <= alu_result;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  // Flags travel with the result so they are valid exactly with out_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_zero   <= 1'b0;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
    end else if (s2_load) begin
      out_zero   <= (alu_result == '0);
      out_ones   <= &alu_result;
      out_parity <= ^alu_result;
    end
  end
`endif

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign occupancy  = {1'b0, s1_valid} + {1'b0, s2_valid};

endmodule
